// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl
//   Run/stop/clear controller for the seconds timer chain. It gates the
//   prescaler chain, consumes the 1 Hz carry, owns the second count and
//   supports a count-up stopwatch mode and a count-down mode with an alarm.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_1s    one-cycle 1 Hz carry from the prescaler chain (used in RUN only)
//   btn_start  start/pause push-button, synchronised level
//   btn_clear  clear push-button, synchronised level
//   mode       0 = count up, 1 = count down (captured on IDLE->RUN)
//   preset     count-down start value (clamped to MAX_CNT)
//   cnt_en     enable to the prescaler chain, high only in RUN
//   cnt_clr    one-cycle synchronous clear to the prescaler chain
//   count      current second value, always within 0..MAX_CNT
//   sec        one-hot decode of count
//   alarm      high while in ALARM
//   state      IDLE=00, RUN=01, PAUSE=10, ALARM=11
module timer_run_ctrl #(
  parameter int CNT_W   = 4,
  parameter int MAX_CNT = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic             btn_start,
  input  logic             btn_clear,
  input  logic             mode,
  input  logic [CNT_W-1:0] preset,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [CNT_W-1:0] count,
  output logic [MAX_CNT:0] sec,
  output logic             alarm,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ZERO_V = '0;
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  // Saturate an out-of-range preset to the top of the count range.
  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    clamp = (v > MAX_V) ? MAX_V : v;
  endfunction

  // Up count, modulo MAX_CNT+1.
  function automatic logic [CNT_W-1:0] inc_wrap(input logic [CNT_W-1:0] v);
    inc_wrap = (v >= MAX_V) ? ZERO_V : v + ONE_V;
  endfunction

  // Down count that never goes below zero.
  function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] v);
    dec_floor = (v == ZERO_V) ? ZERO_V : v - ONE_V;
  endfunction

  state_t           state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             mode_q, mode_n;
  logic             clr_q, clr_n;
  logic             btn_start_q, btn_clear_q;
  logic             start_e, clear_e;
  logic [CNT_W-1:0] idle_load;

  assign start_e = btn_start & ~btn_start_q;
  assign clear_e = btn_clear & ~btn_clear_q;

  // Count used when leaving IDLE: a down run from zero restarts at preset.
  assign idle_load = (mode && count_q == ZERO_V) ? clamp(preset) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mode_q      <= 1'b0;
      clr_q       <= 1'b0;
      btn_start_q <= 1'b0;
      btn_clear_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      count_q     <= count_n;
      mode_q      <= mode_n;
      clr_q       <= clr_n;
      btn_start_q <= btn_start;
      btn_clear_q <= btn_clear;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    mode_n  = mode_q;
    clr_n   = 1'b0;

    if (clear_e) begin
      // Clear outranks tick and start; a start edge in the same cycle is lost.
      clr_n = 1'b1;
      if (state_q == ALARM) begin
        state_n = IDLE;
        count_n = clamp(preset);
      end else begin
        count_n = mode_q ? clamp(preset) : ZERO_V;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_e) begin
            mode_n  = mode;
            count_n = idle_load;
            state_n = (mode && idle_load == ZERO_V) ? ALARM : RUN;
          end
        end
        RUN: begin
          if (tick_1s) begin
            if (!mode_q) begin
              count_n = inc_wrap(count_q);
            end else begin
              count_n = dec_floor(count_q);
            end
          end
          // Reaching zero in down mode wins over a simultaneous pause.
          if (tick_1s && mode_q && count_q <= ONE_V) begin
            state_n = ALARM;
          end else if (start_e) begin
            state_n = PAUSE;
          end
        end
        PAUSE: begin
          if (start_e) begin
            state_n = RUN;
          end
        end
        ALARM: begin
          if (start_e) begin
            state_n = IDLE;
            count_n = clamp(preset);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sec = '0;
    for (int k = 0; k <= MAX_CNT; k++) begin
      sec[k] = (count_q == CNT_W'(k));
    end
  end

  assign cnt_en  = (state_q == RUN);
  assign alarm   = (state_q == ALARM);
  assign state   = state_q;
  assign count   = count_q;
  assign cnt_clr = clr_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// tb_timer_run_ctrl
//   Directed bench for timer_run_ctrl. Each step drives the inputs, queues the
//   expected post-edge outputs and compares them after the clock edge.
module tb_timer_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1s;
  logic       btn_start;
  logic       btn_clear;
  logic       mode;
  logic [3:0] preset;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] count;
  logic [9:0] sec;
  logic       alarm;
  logic [1:0] state;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_ALARM = 2'b11;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] cnt;
    logic       clr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  timer_run_ctrl #(.CNT_W(4), .MAX_CNT(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1s   (tick_1s),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .mode      (mode),
    .preset    (preset),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .count     (count),
    .sec       (sec),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_out();
    exp_t       e;
    string      t;
    logic [9:0] esec;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: queue empty, observed %0d entries required >0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      t    = tag_q.pop_front();
      esec = 10'd1 << e.cnt;
      checks++;
      assert (state === e.st) else begin
        errors++; $error("FAIL %s state: observed %b required %b", t, state, e.st);
      end
      checks++;
      assert (count === e.cnt) else begin
        errors++; $error("FAIL %s count: observed %0d required %0d", t, count, e.cnt);
      end
      checks++;
      assert (sec === esec) else begin
        errors++; $error("FAIL %s sec: observed %b required %b", t, sec, esec);
      end
      checks++;
      assert (cnt_en === (e.st == S_RUN)) else begin
        errors++; $error("FAIL %s cnt_en: observed %b required %b", t, cnt_en, (e.st == S_RUN));
      end
      checks++;
      assert (alarm === (e.st == S_ALARM)) else begin
        errors++; $error("FAIL %s alarm: observed %b required %b", t, alarm, (e.st == S_ALARM));
      end
      checks++;
      assert (cnt_clr === e.clr) else begin
        errors++; $error("FAIL %s cnt_clr: observed %b required %b", t, cnt_clr, e.clr);
      end
    end
  endtask

  task automatic step(input logic s, input logic c, input logic t, input string tag,
                      input logic [1:0] est, input logic [3:0] ecnt, input logic eclr);
    exp_t e;
    btn_start = s;
    btn_clear = c;
    tick_1s   = t;
    e.st  = est;
    e.cnt = ecnt;
    e.clr = eclr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; tick_1s = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
    mode = 1'b0; preset = 4'd0;
    #2;

    // Reset and idle
    step(0, 0, 0, "reset0", S_IDLE, 4'd0, 1'b0);
    step(0, 0, 0, "reset1", S_IDLE, 4'd0, 1'b0);
    rst = 1'b0;
    step(0, 0, 0, "idle", S_IDLE, 4'd0, 1'b0);
    step(0, 0, 1, "idle_tick", S_IDLE, 4'd0, 1'b0);

    // Up mode with wrap
    mode = 1'b0;
    step(1, 0, 0, "up_start", S_RUN, 4'd0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, "up_tick", S_RUN, 4'(i % 10), 1'b0);
    end
    step(0, 0, 0, "up_hold", S_RUN, 4'd2, 1'b0);

    // Clear in RUN, then pause/resume with a held button
    step(0, 1, 0, "run_clear", S_RUN, 4'd0, 1'b1);
    step(0, 1, 0, "clear_held", S_RUN, 4'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, "pre_pause", S_RUN, 4'(i), 1'b0);
    end
    step(1, 0, 0, "pause", S_PAUSE, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, "pause_held", S_PAUSE, 4'd3, 1'b0);
    end
    step(0, 0, 1, "pause_rel", S_PAUSE, 4'd3, 1'b0);
    step(1, 0, 0, "resume", S_RUN, 4'd3, 1'b0);
    step(0, 0, 1, "resume_tick", S_RUN, 4'd4, 1'b0);

    // Clear beats tick and start
    step(0, 0, 1, "to5", S_RUN, 4'd5, 1'b0);
    step(1, 1, 1, "clr_prio", S_RUN, 4'd0, 1'b1);
    step(0, 0, 0, "clr_pulse_end", S_RUN, 4'd0, 1'b0);

    // Tick and start together: tick applied, then PAUSE
    step(0, 0, 1, "tick1", S_RUN, 4'd1, 1'b0);
    step(1, 0, 1, "tick_start", S_PAUSE, 4'd2, 1'b0);
    step(0, 0, 0, "paused", S_PAUSE, 4'd2, 1'b0);
    step(0, 1, 0, "pause_clear", S_PAUSE, 4'd0, 1'b1);
    step(0, 0, 0, "pause_clr_end", S_PAUSE, 4'd0, 1'b0);

    // Mid-RUN reset
    step(1, 0, 0, "run_again", S_RUN, 4'd0, 1'b0);
    step(0, 0, 1, "run_tick", S_RUN, 4'd1, 1'b0);
    rst = 1'b1;
    step(0, 0, 1, "mid_rst", S_IDLE, 4'd0, 1'b0);
    rst = 1'b0;
    step(0, 0, 0, "post_rst", S_IDLE, 4'd0, 1'b0);

    // Countdown to alarm
    mode = 1'b1; preset = 4'd3;
    step(1, 0, 0, "dn_start", S_RUN, 4'd3, 1'b0);
    step(0, 0, 1, "dn2", S_RUN, 4'd2, 1'b0);
    step(0, 0, 1, "dn1", S_RUN, 4'd1, 1'b0);
    step(0, 0, 1, "dn0", S_ALARM, 4'd0, 1'b0);
    step(0, 0, 1, "alarm_tick", S_ALARM, 4'd0, 1'b0);
    step(1, 0, 0, "alarm_ack", S_IDLE, 4'd3, 1'b0);
    step(0, 0, 0, "idle_after", S_IDLE, 4'd3, 1'b0);

    // Preset clamp
    rst = 1'b1;
    step(0, 0, 0, "rst_clamp", S_IDLE, 4'd0, 1'b0);
    rst = 1'b0;
    preset = 4'd12;
    step(1, 0, 0, "clamp_start", S_RUN, 4'd9, 1'b0);
    step(0, 0, 1, "clamp_tick", S_RUN, 4'd8, 1'b0);
    step(0, 1, 0, "dn_clear", S_RUN, 4'd9, 1'b1);

    // Zero preset goes straight to ALARM; clear leaves ALARM
    rst = 1'b1;
    step(0, 0, 0, "rst_zero", S_IDLE, 4'd0, 1'b0);
    rst = 1'b0;
    preset = 4'd0;
    step(1, 0, 0, "zero_start", S_ALARM, 4'd0, 1'b0);
    preset = 4'd6;
    step(0, 1, 0, "alarm_clear", S_IDLE, 4'd6, 1'b1);
    step(0, 0, 0, "alarm_clr_end", S_IDLE, 4'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
